// File: rtl/led_fx_pkg.sv
// rtl/led_fx_pkg.sv - shared types and frame-length helper for the LED effect driver
package led_fx_pkg;

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    CHASE  = 2'd1,
    BOUNCE = 2'd2,
    FILL   = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } led_fx_state_t;

  // Steps in one complete frame of the given pattern.
  function automatic int frame_len(led_mode_t mode, int n_led);
    case (mode)
      BLINK:   return 2;
      CHASE:   return n_led;
      BOUNCE:  return 2 * n_led - 2;
      default: return n_led + 1;
    endcase
  endfunction

endpackage

// File: rtl/led_fx_prescaler.sv
// rtl/led_fx_prescaler.sv - free-running step-tick divider with synchronous clear
module led_fx_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_fx_driver.sv
// rtl/led_fx_driver.sv - N-LED animated indicator driver with optional finite burst
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int N_LED  = 8,
  parameter int DIV    = 25_000_000,
  parameter int BURSTS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int SW  = $clog2(2 * N_LED);
  localparam int FLW = SW + 1;
  localparam int FW  = (BURSTS > 0) ? (($clog2(BURSTS + 1) > 1) ? $clog2(BURSTS + 1) : 1) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'((BURSTS > 0) ? BURSTS - 1 : 0);

  led_fx_state_t   state;
  led_mode_t       mode_q;
  logic [SW-1:0]   step;
  logic [SW-1:0]   next_step;
  logic [FW-1:0]   frame;
  logic [FLW-1:0]  flen;
  logic            tick;
  logic            last_step;
  logic            burst_end;

  function automatic logic [N_LED-1:0] pattern(led_mode_t m, logic [SW-1:0] s);
    logic [SW-1:0] pos;
    // Bounce folds the second half of the frame back toward LED 0 without repeating the ends.
    pos = (s < SW'(N_LED)) ? s : SW'(2 * N_LED - 2) - s;
    case (m)
      BLINK:   pattern = s[0] ? '0 : '1;
      CHASE:   pattern = {{(N_LED-1){1'b0}}, 1'b1} << s;
      BOUNCE:  pattern = {{(N_LED-1){1'b0}}, 1'b1} << pos;
      default: pattern = N_LED'(({{N_LED{1'b0}}, 1'b1} << s) - 1'b1);
    endcase
  endfunction

  led_fx_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(state != RUN),
    .tick (tick)
  );

  assign flen      = FLW'(frame_len(mode_q, N_LED));
  assign last_step = ({1'b0, step} == (flen - 1'b1));
  assign next_step = last_step ? '0 : step + 1'b1;
  assign burst_end = (BURSTS > 0) && tick && last_step && (frame == LAST_FRAME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= BLINK;
      step   <= '0;
      frame  <= '0;
      led    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state  <= RUN;
            mode_q <= led_mode_t'(mode);
            step   <= '0;
            frame  <= '0;
            led    <= pattern(led_mode_t'(mode), '0);
            busy   <= 1'b1;
          end
        end
        RUN: begin
          // Completion wins over a simultaneous en drop, but then skips HOLD.
          if (burst_end) begin
            done  <= 1'b1;
            led   <= '0;
            busy  <= 1'b0;
            state <= en ? HOLD : IDLE;
          end else if (!en) begin
            led   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            step <= next_step;
            if (last_step) begin
              frame <= frame + 1'b1;
            end
            led <= pattern(mode_q, next_step);
          end
        end
        HOLD: begin
          if (!en) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          led   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fx_driver.sv
// tb/tb_led_fx_driver.sv - bench for led_fx_driver with BURSTS = 0, 1, 2 instances
module tb_led_fx_driver;

  localparam int N   = 4;
  localparam int DIV = 3;

  logic       clk;
  logic       rst;
  logic       en     [3];
  logic [1:0] mode   [3];
  logic [3:0] led_o  [3];
  logic       busy_o [3];
  logic       done_o [3];

  int checks;
  int errors;

  led_fx_driver #(.N_LED(N), .DIV(DIV), .BURSTS(0)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .mode(mode[0]),
    .led(led_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  led_fx_driver #(.N_LED(N), .DIV(DIV), .BURSTS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .mode(mode[1]),
    .led(led_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  led_fx_driver #(.N_LED(N), .DIV(DIV), .BURSTS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en[2]), .mode(mode[2]),
    .led(led_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int flen(int m);
    case (m)
      0:       return 2;
      1:       return N;
      2:       return 2 * N - 2;
      default: return N + 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_pat(int m, int s);
    int pos;
    case (m)
      0: return (s % 2 == 0) ? 4'hF : 4'h0;
      1: return 4'(1 << s);
      2: begin
        pos = (s < N) ? s : 2 * N - 2 - s;
        return 4'(1 << pos);
      end
      default: return 4'((1 << s) - 1);
    endcase
  endfunction

  // Instance b has BURSTS = b. Called on a negedge with the instance idle.
  task automatic run(input int b, input int m, input int ncyc, input int drop_at, input bit flip);
    int total;
    int step;
    logic [3:0] el;
    logic eb;
    logic ed;
    total = b * flen(m) * DIV;
    en[b] = 1'b1;
    mode[b] = 2'(m);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      step = t / DIV;
      if (b > 0 && t >= total && drop_at >= total) begin
        el = 4'h0; eb = 1'b0; ed = (t == total);
      end else if (t >= drop_at) begin
        el = 4'h0; eb = 1'b0; ed = 1'b0;
      end else begin
        el = exp_pat(m, step % flen(m)); eb = 1'b1; ed = 1'b0;
      end
      chk($sformatf("led b%0d m%0d t%0d", b, m, t), 32'(led_o[b]), 32'(el));
      chk($sformatf("busy b%0d m%0d t%0d", b, m, t), 32'(busy_o[b]), 32'(eb));
      chk($sformatf("done b%0d m%0d t%0d", b, m, t), 32'(done_o[b]), 32'(ed));
      if (flip && t == 2) mode[b] = 2'((m + 1 + $urandom_range(0, 2)) % 4);
      en[b] = (t + 1 < drop_at);
    end
  endtask

  task automatic settle(input int b);
    en[b] = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("idle_led b%0d", b), 32'(led_o[b]), 32'h0);
    chk($sformatf("idle_busy b%0d", b), 32'(busy_o[b]), 32'h0);
    chk($sformatf("idle_done b%0d", b), 32'(done_o[b]), 32'h0);
  endtask

  initial begin
    int b;
    int m;
    int total;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      mode[i] = 2'd0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_led b%0d", i), 32'(led_o[i]), 32'h0);
      chk($sformatf("rst_busy b%0d", i), 32'(busy_o[i]), 32'h0);
      chk($sformatf("rst_done b%0d", i), 32'(done_o[i]), 32'h0);
    end

    // Asynchronous reset in the middle of a CHASE run.
    mode[0] = 2'd1;
    en[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("chase_pre_rst", 32'(led_o[0]), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led_o[0]), 32'h0);
    chk("async_rst_busy", 32'(busy_o[0]), 32'h0);
    chk("async_rst_done", 32'(done_o[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_led", 32'(led_o[0]), 32'h1);
    chk("restart_busy", 32'(busy_o[0]), 32'h1);
    settle(0);

    run(0, 0, 12, 1000, 1'b0);
    settle(0);
    run(1, 2, 24, 1000, 1'b0);
    settle(1);
    run(2, 3, 36, 1000, 1'b0);
    settle(2);
    run(2, 1, 10, 7, 1'b1);
    settle(2);

    // Drop en exactly on the expiry edge, then raise it at once: only IDLE may restart.
    run(1, 1, 13, 12, 1'b0);
    en[1] = 1'b1;
    @(negedge clk);
    chk("sim_restart_busy", 32'(busy_o[1]), 32'h1);
    chk("sim_restart_led", 32'(led_o[1]), 32'h1);
    settle(1);

    for (int it = 0; it < 10; it++) begin
      b = $urandom_range(0, 2);
      m = $urandom_range(0, 3);
      total = b * flen(m) * DIV;
      if (b > 0 && $urandom_range(0, 3) == 0) begin
        run(b, m, total + 3, total, 1'b1);
      end else begin
        run(b, m, $urandom_range(4, 40), $urandom_range(1, 45), 1'b1);
      end
      settle(b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fx_driver.md
# led_fx_driver

Parametrised LED effect driver for the digital clock's indicator bank (alarm, timer expiry, setting-mode flash). It generalises the fixed 8-LED all-on/all-off blinker to N LEDs and four animated patterns. It generates its own step tick from the system clock and supports an optional finite burst length with a completion pulse. It sits between the alarm/control logic (which drives `en` and `mode`) and the board LED pins.

## Interface
Parameters:
- `N_LED`, 8: number of LED outputs; legal range ≥ 2.
- `DIV`, 25_000_000: `clk` cycles per pattern step; legal range ≥ 2.
- `BURSTS`, 0: number of complete pattern frames per activation; 0 means run for as long as `en` is high.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level request to run the effect.
- `mode`  in  2  pattern select: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 FILL.
- `led`  out  N_LED  LED drive, registered; 1 = lit.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a finite burst completes.

## Operation
- States:
  - IDLE: `led` = 0.
  - RUN: a pattern is animating.
  - HOLD: the burst has finished and the block waits for `en` = 0.
- IDLE→RUN when `en` = 1 at a clock edge. At that edge:
  - `mode` is latched; `mode` changes during RUN are ignored.
  - The prescaler and step counter are cleared.
  - The frame counter is cleared.
- RUN→IDLE when `en` = 0 at any edge. `led` → 0 and `done` stays low. An abort is not a completion.
- RUN→HOLD when `BURSTS` > 0 and the last step of frame number `BURSTS` expires. `done` = 1 for that single cycle and `led` → 0.
- HOLD→IDLE when `en` = 0. A new run therefore requires `en` to fall and rise again.
- Patterns, with step index s starting at 0; one frame is the full set of steps listed:
  - BLINK: all ones when s is even, all zeros when s is odd. Frame = 2 steps.
  - CHASE: one-hot `1 << s`. Frame = N_LED steps; wraps MSB→LSB.
  - BOUNCE: one-hot position 0,1,…,N_LED−1,N_LED−2,…,1. Frame = 2·N_LED−2 steps. The end LEDs are not repeated at the turn.
  - FILL: the low s bits are ones (bar graph), s = 0…N_LED. Frame = N_LED+1 steps; step 0 is all off.
- Width rules:
  - Prescaler: `$clog2(DIV)` bits, counting 0…DIV−1.
  - Step counter: `$clog2(2·N_LED)` bits.
  - Frame counter: `$clog2(BURSTS+1)` bits, with a minimum of 1.
- All counters wrap or clear explicitly. Unsigned compares only.

## Timing
- Reset values: `led` = 0, `busy` = 0, `done` = 0. State is IDLE and all counters are 0.
- Reset mid-RUN is asynchronous. Outputs go to their reset values immediately. No `done` is produced.
- Latency on entry: with `en` sampled high at edge k, `busy` = 1 and `led` shows the step-0 pattern after edge k.
- Step timing: step s is displayed for exactly DIV cycles, over edges k+s·DIV … k+(s+1)·DIV−1.
- Exit on `en` low: `en` sampled low at edge j gives `led` = 0 and `busy` = 0 after edge j. This takes one cycle.
- Burst end: for a burst of F steps per frame, `done` is high for the cycle after edge k+BURSTS·F·DIV. `led` = 0 and `busy` = 0 from that same edge.
- Simultaneous events: if `en` falls on the same edge the burst expires, the completion takes priority. `done` pulses and the next state is IDLE, not HOLD.

## Structure
- Shared package `led_fx_pkg` holds:
  - `led_mode_t` enum: BLINK, CHASE, BOUNCE, FILL.
  - `led_fx_state_t` enum: IDLE, RUN, HOLD.
  - Frame-length function `frame_len(mode, n_led)`.
- Sub-module `led_fx_prescaler`:
  - Parameter `DIV`.
  - Inputs: `clk`, `rst`, and a synchronous `clear`.
  - Output: a 1-cycle `tick` when the count reaches DIV−1.
- The top level holds the FSM, the step and frame counters, and the registered pattern decoder.

## Test plan
All scenarios use `N_LED`=4, `DIV`=3.
- Reset check (`BURSTS`=0): assert `rst` mid-CHASE → `led`=0000, `busy`=0, `done`=0 at once; after release, `en`=1 restarts at 0001.
- BLINK (`BURSTS`=0): hold `en`=1 for 12 cycles → `led` = 1111×3, 0000×3, 1111×3, 0000×3; `done` never pulses.
- BOUNCE (`BURSTS`=1) → `led` sequence 0001, 0010, 0100, 1000, 0100, 0010 at 3 cycles each; `done` pulses once at cycle 18; then HOLD with `led`=0 while `en` stays 1.
- FILL (`BURSTS`=2) → sequence 0000, 0001, 0011, 0111, 1111, repeated twice; `done` at cycle 30; re-raising `en` without first dropping it produces no activity.
- CHASE abort (`BURSTS`=2): drop `en` at cycle 7 → `led`=0000 on the next edge; `done` stays 0; switching `mode` to FILL during the run has no effect.
- Simultaneous-event check (CHASE, `BURSTS`=1): drop `en` on the expiry edge (cycle 12) → `done` pulses and the state returns to IDLE.
